tank_motion: RTL and testbench



---
 rtl/tank_motion.sv | 217 +++++++++++++++++++++
 tb/tb_tank_motion.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tank_motion.sv
// ============================================================================
// tank_motion
// ----------------------------------------------------------------------------
// Per-frame motion controller for one player tank. Decodes up to two USB
// keycodes into forward/reverse motion and rate-limited CCW/CW turning over
// 8 headings, clamps each axis independently against the playfield edges
// (so diagonal motion into an edge slides along it), honours a same-frame
// wall veto from the collision map, and supports respawn. Steps once per
// frame_clk edge.
//
// Optional feature macro: TANK_MOTION_BOOST_EN
//   When defined, an extra input 'boost' doubles the per-axis step while
//   moving; an axis whose boosted candidate is out of range retries at the
//   normal step before holding.
//
// Ports:
//   frame_clk   in   1      sole clock, one edge per video frame
//   Reset_n     in   1      synchronous reset, active low
//   keycode0    in   8      first pressed key (8'h00 = none)
//   keycode1    in   8      second pressed key (8'h00 = none)
//   respawn     in   1      load spawn state at next edge
//   wall_block  in   1      map reports NextX/NextY overlaps a wall
//   boost       in   1      (TANK_MOTION_BOOST_EN only) double step
//   NextX       out  POS_W  combinational candidate X for this frame
//   NextY       out  POS_W  combinational candidate Y for this frame
//   TankX       out  POS_W  registered X
//   TankY       out  POS_W  registered Y
//   TankS       out  POS_W  constant tank half-size
//   TankDir     out  3      registered heading (0=E, counting CCW)
//   Moving      out  1      registered; position changed at last edge
// ============================================================================
module tank_motion #(
    parameter int         POS_W      = 10,
    parameter int         X_MIN      = 0,
    parameter int         X_MAX      = 639,
    parameter int         Y_MIN      = 0,
    parameter int         Y_MAX      = 479,
    parameter int         X_START    = 320,
    parameter int         Y_START    = 240,
    parameter int         SIZE       = 4,
    parameter int         STEP       = 1,
    parameter int         TURN_DELAY = 4,
    parameter logic [7:0] KEY_FWD    = 8'h1A,
    parameter logic [7:0] KEY_BACK   = 8'h16,
    parameter logic [7:0] KEY_LEFT   = 8'h04,
    parameter logic [7:0] KEY_RIGHT  = 8'h07
) (
    input  logic             frame_clk,
    input  logic             Reset_n,
    input  logic [7:0]       keycode0,
    input  logic [7:0]       keycode1,
    input  logic             respawn,
    input  logic             wall_block,
`ifdef TANK_MOTION_BOOST_EN
    input  logic             boost,
`endif
    output logic [POS_W-1:0] NextX,
    output logic [POS_W-1:0] NextY,
    output logic [POS_W-1:0] TankX,
    output logic [POS_W-1:0] TankY,
    output logic [POS_W-1:0] TankS,
    output logic [2:0]       TankDir,
    output logic             Moving
);

    // Two extra bits give headroom for sign and overflow so that
    // candidates just below zero are seen as negative rather than wrapping.
    localparam int SW    = POS_W + 2;
    localparam int CNT_W = (TURN_DELAY > 1) ? $clog2(TURN_DELAY) : 1;

    localparam logic signed [SW-1:0] SIZE_S  = SW'(SIZE);
    localparam logic signed [SW-1:0] STEP_S  = SW'(STEP);
    localparam logic signed [SW-1:0] X_MIN_S = SW'(X_MIN);
    localparam logic signed [SW-1:0] X_MAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0] Y_MIN_S = SW'(Y_MIN);
    localparam logic signed [SW-1:0] Y_MAX_S = SW'(Y_MAX);

    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    logic [2:0]       r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic             r_moving;

    logic w_fwd, w_back, w_left, w_right;
    logic w_fwdAct, w_backAct, w_leftAct, w_rightAct;
    logic signed [1:0]    w_ux, w_uy;
    logic signed [SW-1:0] w_dx, w_dy;
    logic signed [SW-1:0] w_xs, w_ys;
    logic signed [SW-1:0] w_cx, w_cy;
    logic [2:0]           w_nextDir;
    logic [CNT_W-1:0]     w_nextCnt;

    // True when a tank centred on c stays entirely within [lo, hi].
    function automatic logic fits(input logic signed [SW-1:0] c,
                                  input logic signed [SW-1:0] lo,
                                  input logic signed [SW-1:0] hi);
        return ((c - SIZE_S) >= lo) && ((c + SIZE_S) <= hi);
    endfunction

    // Unit X component of a heading (screen coordinates).
    function automatic logic signed [1:0] unitX(input logic [2:0] d);
        case (d)
            3'd0, 3'd1, 3'd7: return 2'sd1;
            3'd3, 3'd4, 3'd5: return -2'sd1;
            default:          return 2'sd0;
        endcase
    endfunction

    // Unit Y component of a heading; Y grows downward, so north is -1.
    function automatic logic signed [1:0] unitY(input logic [2:0] d);
        case (d)
            3'd1, 3'd2, 3'd3: return -2'sd1;
            3'd5, 3'd6, 3'd7: return 2'sd1;
            default:          return 2'sd0;
        endcase
    endfunction

    // Key decode: a key counts if either keycode slot carries it, and
    // opposing keys held together cancel each other.
    always_comb begin
        w_fwd      = (keycode0 == KEY_FWD)   || (keycode1 == KEY_FWD);
        w_back     = (keycode0 == KEY_BACK)  || (keycode1 == KEY_BACK);
        w_left     = (keycode0 == KEY_LEFT)  || (keycode1 == KEY_LEFT);
        w_right    = (keycode0 == KEY_RIGHT) || (keycode1 == KEY_RIGHT);
        w_fwdAct   = w_fwd   & ~w_back;
        w_backAct  = w_back  & ~w_fwd;
        w_leftAct  = w_left  & ~w_right;
        w_rightAct = w_right & ~w_left;
    end

    // Motion vector from the heading held before this edge; a turn taken at
    // the same edge only affects motion from the following frame.
    always_comb begin
        w_ux = unitX(r_dir);
        w_uy = unitY(r_dir);
        w_dx = '0;
        w_dy = '0;
        if (w_fwdAct) begin
            w_dx = SW'(w_ux) * STEP_S;
            w_dy = SW'(w_uy) * STEP_S;
        end else if (w_backAct) begin
            w_dx = -(SW'(w_ux) * STEP_S);
            w_dy = -(SW'(w_uy) * STEP_S);
        end
    end

    // Per-axis candidate with independent clamping: an axis that would push
    // the tank past its edge simply holds while the other axis still moves.
    always_comb begin
        w_xs = $signed({2'b00, r_x});
        w_ys = $signed({2'b00, r_y});
        w_cx = w_xs;
        w_cy = w_ys;
`ifdef TANK_MOTION_BOOST_EN
        if (boost && fits(w_xs + (w_dx <<< 1), X_MIN_S, X_MAX_S))
            w_cx = w_xs + (w_dx <<< 1);
        else if (fits(w_xs + w_dx, X_MIN_S, X_MAX_S))
            w_cx = w_xs + w_dx;
        if (boost && fits(w_ys + (w_dy <<< 1), Y_MIN_S, Y_MAX_S))
            w_cy = w_ys + (w_dy <<< 1);
        else if (fits(w_ys + w_dy, Y_MIN_S, Y_MAX_S))
            w_cy = w_ys + w_dy;
`else
        if (fits(w_xs + w_dx, X_MIN_S, X_MAX_S))
            w_cx = w_xs + w_dx;
        if (fits(w_ys + w_dy, Y_MIN_S, Y_MAX_S))
            w_cy = w_ys + w_dy;
`endif
    end

    // Turn rate limiter: a turn fires only when the counter is idle, then
    // the counter spaces out repeats while the key stays held. Releasing
    // the turn keys clears it so a fresh tap responds immediately.
    always_comb begin
        w_nextDir = r_dir;
        w_nextCnt = r_cnt;
        if (!(w_leftAct || w_rightAct)) begin
            w_nextCnt = '0;
        end else if (r_cnt == '0) begin
            w_nextDir = w_leftAct ? (r_dir + 3'd1) : (r_dir - 3'd1);
            w_nextCnt = CNT_W'(TURN_DELAY - 1);
        end else begin
            w_nextCnt = r_cnt - CNT_W'(1);
        end
    end

    // State update: reset and respawn both load the spawn state; otherwise
    // the wall veto freezes both axes for this frame.
    always_ff @(posedge frame_clk) begin
        if (!Reset_n || respawn) begin
            r_x      <= POS_W'(X_START);
            r_y      <= POS_W'(Y_START);
            r_dir    <= 3'd0;
            r_cnt    <= '0;
            r_moving <= 1'b0;
        end else begin
            r_dir <= w_nextDir;
            r_cnt <= w_nextCnt;
            if (wall_block) begin
                r_moving <= 1'b0;
            end else begin
                r_x      <= NextX;
                r_y      <= NextY;
                r_moving <= (NextX != r_x) || (NextY != r_y);
            end
        end
    end

    assign NextX   = w_cx[POS_W-1:0];
    assign NextY   = w_cy[POS_W-1:0];
    assign TankX   = r_x;
    assign TankY   = r_y;
    assign TankS   = POS_W'(SIZE);
    assign TankDir = r_dir;
    assign Moving  = r_moving;

endmodule

// File: tb/tb_tank_motion.sv
// ============================================================================
// tb_tank_motion
// ----------------------------------------------------------------------------
// Directed self-checking bench for tank_motion with default parameters
// (640x480 field, spawn 320/240, half-size 4, step 1, turn delay 4).
// Inputs change 1 time unit after each rising frame_clk edge and outputs
// are sampled at the same point, well away from the next edge.
// ============================================================================
module tb_tank_motion;

    logic       frame_clk;
    logic       Reset_n;
    logic [7:0] keycode0;
    logic [7:0] keycode1;
    logic       respawn;
    logic       wall_block;
    logic [9:0] NextX, NextY, TankX, TankY, TankS;
    logic [2:0] TankDir;
    logic       Moving;

    int checks = 0;
    int errors = 0;

    tank_motion dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode0  (keycode0),
        .keycode1  (keycode1),
        .respawn   (respawn),
        .wall_block(wall_block),
        .NextX     (NextX),
        .NextY     (NextY),
        .TankX     (TankX),
        .TankY     (TankY),
        .TankS     (TankS),
        .TankDir   (TankDir),
        .Moving    (Moving)
    );

    // Free-running frame clock.
    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Advance one frame and settle just past the edge.
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Return to spawn with no keys held.
    task automatic doRespawn();
        keycode0 = 8'h00;
        keycode1 = 8'h00;
        respawn  = 1'b1;
        tick();
        respawn  = 1'b0;
    endtask

    // Reset state after two low edges.
    task automatic test_reset();
        Reset_n = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        #1;
        checks++; if (TankX !== 10'd320) begin errors++; $display("[TB] FAIL reset_x got %0d want 320", TankX); end
        checks++; if (TankY !== 10'd240) begin errors++; $display("[TB] FAIL reset_y got %0d want 240", TankY); end
        checks++; if (TankDir !== 3'd0) begin errors++; $display("[TB] FAIL reset_dir got %0d want 0", TankDir); end
        checks++; if (Moving !== 1'b0) begin errors++; $display("[TB] FAIL reset_moving got %0b want 0", Moving); end
        checks++; if (TankS !== 10'd4) begin errors++; $display("[TB] FAIL tank_s got %0d want 4", TankS); end
        checks++; if (NextX !== 10'd320 || NextY !== 10'd240) begin errors++; $display("[TB] FAIL idle_next got %0d,%0d want 320,240", NextX, NextY); end
    endtask

    // Forward east three frames, then one frame in reverse.
    task automatic test_forward();
        keycode0 = 8'h1A;
        #1;
        checks++; if (NextX !== 10'd321) begin errors++; $display("[TB] FAIL fwd_nextx got %0d want 321", NextX); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (TankX !== 10'(320 + i) || TankY !== 10'd240) begin errors++; $display("[TB] FAIL fwd_pos f%0d got %0d,%0d want %0d,240", i, TankX, TankY, 320 + i); end
            checks++; if (Moving !== 1'b1 || TankDir !== 3'd0) begin errors++; $display("[TB] FAIL fwd_mv_dir f%0d got %0b,%0d want 1,0", i, Moving, TankDir); end
        end
        keycode0 = 8'h16;
        tick();
        checks++; if (TankX !== 10'd322 || Moving !== 1'b1) begin errors++; $display("[TB] FAIL back_pos got %0d,%0b want 322,1", TankX, Moving); end
    endtask

    // Held left turns are spaced by the turn delay; taps act at once; wraps.
    task automatic test_turn();
        int expDir[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 3};
        doRespawn();
        keycode0 = 8'h04;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++; if (TankDir !== 3'(expDir[i])) begin errors++; $display("[TB] FAIL hold_left f%0d got %0d want %0d", i + 1, TankDir, expDir[i]); end
        end
        checks++; if (TankX !== 10'd320 || Moving !== 1'b0) begin errors++; $display("[TB] FAIL turn_still got %0d,%0b want 320,0", TankX, Moving); end
        keycode0 = 8'h00;
        tick();
        keycode0 = 8'h04;
        tick();
        checks++; if (TankDir !== 3'd4) begin errors++; $display("[TB] FAIL tap_left got %0d want 4", TankDir); end
        doRespawn();
        keycode0 = 8'h07;
        tick();
        checks++; if (TankDir !== 3'd7) begin errors++; $display("[TB] FAIL right_wrap got %0d want 7", TankDir); end
        keycode0 = 8'h00;
        tick();
        keycode1 = 8'h04;
        tick();
        checks++; if (TankDir !== 3'd0) begin errors++; $display("[TB] FAIL left_wrap got %0d want 0", TankDir); end
        keycode1 = 8'h00;
    endtask

    // Opposing keys cancel; turning while moving uses the old heading first.
    task automatic test_combo();
        doRespawn();
        keycode0 = 8'h1A;
        keycode1 = 8'h16;
        tick();
        checks++; if (TankX !== 10'd320 || TankY !== 10'd240 || Moving !== 1'b0) begin errors++; $display("[TB] FAIL fwd_back_cancel got %0d,%0d,%0b want 320,240,0", TankX, TankY, Moving); end
        keycode0 = 8'h04;
        keycode1 = 8'h07;
        tick();
        checks++; if (TankDir !== 3'd0) begin errors++; $display("[TB] FAIL left_right_cancel got %0d want 0", TankDir); end
        keycode0 = 8'h1A;
        keycode1 = 8'h04;
        tick();
        checks++; if (TankX !== 10'd321 || TankY !== 10'd240 || TankDir !== 3'd1) begin errors++; $display("[TB] FAIL move_turn_f1 got %0d,%0d,%0d want 321,240,1", TankX, TankY, TankDir); end
        tick();
        checks++; if (TankX !== 10'd322 || TankY !== 10'd239 || TankDir !== 3'd1) begin errors++; $display("[TB] FAIL move_turn_f2 got %0d,%0d,%0d want 322,239,1", TankX, TankY, TankDir); end
    endtask

    // Wall veto freezes position; release resumes on the next edge.
    task automatic test_wall();
        doRespawn();
        keycode0   = 8'h1A;
        wall_block = 1'b1;
        tick();
        tick();
        checks++; if (TankX !== 10'd320 || TankY !== 10'd240 || Moving !== 1'b0) begin errors++; $display("[TB] FAIL wall_hold got %0d,%0d,%0b want 320,240,0", TankX, TankY, Moving); end
        wall_block = 1'b0;
        tick();
        checks++; if (TankX !== 10'd321 || Moving !== 1'b1) begin errors++; $display("[TB] FAIL wall_release got %0d,%0b want 321,1", TankX, Moving); end
    endtask

    // NE run from spawn: Y stops at 4 (top edge), X slides on to 635.
    task automatic test_clamp();
        doRespawn();
        keycode0 = 8'h04;
        tick();
        keycode0 = 8'h1A;
        for (int i = 0; i < 236; i++) tick();
        checks++; if (TankX !== 10'd556 || TankY !== 10'd4) begin errors++; $display("[TB] FAIL clamp_top got %0d,%0d want 556,4", TankX, TankY); end
        tick();
        checks++; if (TankX !== 10'd557 || TankY !== 10'd4 || Moving !== 1'b1) begin errors++; $display("[TB] FAIL slide_top got %0d,%0d,%0b want 557,4,1", TankX, TankY, Moving); end
        for (int i = 0; i < 78; i++) tick();
        checks++; if (TankX !== 10'd635 || TankY !== 10'd4) begin errors++; $display("[TB] FAIL clamp_corner got %0d,%0d want 635,4", TankX, TankY); end
        checks++; if (NextX !== 10'd635 || NextY !== 10'd4) begin errors++; $display("[TB] FAIL corner_next got %0d,%0d want 635,4", NextX, NextY); end
        tick();
        checks++; if (TankX !== 10'd635 || TankY !== 10'd4 || Moving !== 1'b0) begin errors++; $display("[TB] FAIL corner_hold got %0d,%0d,%0b want 635,4,0", TankX, TankY, Moving); end
    endtask

    // Respawn and reset mid-motion both override held keys.
    task automatic test_respawn();
        keycode0 = 8'h1A;
        keycode1 = 8'h04;
        respawn  = 1'b1;
        tick();
        respawn  = 1'b0;
        checks++; if (TankX !== 10'd320 || TankY !== 10'd240 || TankDir !== 3'd0 || Moving !== 1'b0) begin errors++; $display("[TB] FAIL respawn got %0d,%0d,%0d,%0b want 320,240,0,0", TankX, TankY, TankDir, Moving); end
        keycode1 = 8'h00;
        tick();
        tick();
        checks++; if (TankX !== 10'd322 || Moving !== 1'b1) begin errors++; $display("[TB] FAIL after_respawn got %0d,%0b want 322,1", TankX, Moving); end
        keycode1 = 8'h07;
        Reset_n  = 1'b0;
        tick();
        Reset_n  = 1'b1;
        checks++; if (TankX !== 10'd320 || TankY !== 10'd240 || TankDir !== 3'd0 || Moving !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset got %0d,%0d,%0d,%0b want 320,240,0,0", TankX, TankY, TankDir, Moving); end
    endtask

    initial begin
        Reset_n    = 1'b0;
        keycode0   = 8'h00;
        keycode1   = 8'h00;
        respawn    = 1'b0;
        wall_block = 1'b0;
        test_reset();
        test_forward();
        test_turn();
        test_combo();
        test_wall();
        test_clamp();
        test_respawn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
